issue_scheduler: RTL and testbench

Out-of-order issue queue and arbiter shared by one execution unit (adder/logCmp/shift class). Sits between dispatch and the execution unit. Holds dispatched micro-ops and wakes them from the physical-register written vector. Selects the oldest ready entry each cycle into a registered output stage.

---
 rtl/issue_scheduler_pkg.sv | 20 ++
 rtl/issue_age_select.sv | 27 ++
 rtl/issue_scheduler.sv | 145 ++++++++++++++
 tb/tb_issue_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared constants and helpers for the issue queue.
package issue_scheduler_pkg;

   localparam int unsigned ISQ_DP = 8;             // queue entries
   localparam int unsigned ISQ_DW = 160;           // opaque issue-info payload width
   localparam int unsigned ISQ_RB = 2;             // rename-buffer index bits
   localparam int unsigned ISQ_RP = 1 << ISQ_RB;   // rename buffers per arch register
   localparam int unsigned NAME_W = 5 + ISQ_RB;    // renamed name {arch, buf}
   localparam int unsigned WB_W   = 32 * ISQ_RP;   // physical-register written vector

   typedef enum logic {StEmpty, StFull} out_state_e;

   // Since RP == 2**RB, {arch, buf} is directly the bit index arch*RP + buf.
   function automatic logic src_ok(input logic                need,
                                   input logic [NAME_W-1:0]   name,
                                   input logic [WB_W-1:0]     written);
      return ~need | written[name];
   endfunction

endpackage

// File: rtl/issue_age_select.sv
// Combinational oldest-ready picker over an age matrix (old[j][i]=1: j older than i).
module issue_age_select #(
   parameter int unsigned DP = 8
) (
   input  logic [DP-1:0] i_ready,
   input  logic [DP-1:0] i_old [DP],
   output logic [DP-1:0] o_grant,
   output logic          o_grant_vld
);

   for (genvar gi = 0; gi < DP; gi++) begin : g_col
      logic [DP-1:0] w_older;

      // Collect entries recorded as older than entry gi.
      always_comb begin
         w_older = '0;
         for (int j = 0; j < DP; j++) begin
            w_older[j] = i_old[j][gi] & (j != gi);
         end
      end

      assign o_grant[gi] = i_ready[gi] & ~|(w_older & i_ready);
   end

   assign o_grant_vld = |o_grant;

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue with oldest-ready select into a registered output stage.
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int unsigned DP = ISQ_DP,
   parameter int unsigned DW = ISQ_DW
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              flush,
   input  logic              buffer_push,
   output logic              buffer_full,
   output logic [DP-1:0]     buffer_malloc,
   input  logic [DW-1:0]     dispat_info,
   input  logic [NAME_W-1:0] src1_name,
   input  logic [NAME_W-1:0] src2_name,
   input  logic              src1_need,
   input  logic              src2_need,
   input  logic [WB_W-1:0]   wb_written,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [DW-1:0]     issue_info
);

   logic [DP-1:0]     r_valid;
   logic [DW-1:0]     r_payload [DP];
   logic [NAME_W-1:0] r_src1 [DP];
   logic [NAME_W-1:0] r_src2 [DP];
   logic [DP-1:0]     r_need1;
   logic [DP-1:0]     r_need2;
   logic [DP-1:0]     r_old [DP];

   out_state_e        r_state;
   out_state_e        w_state_nxt;
   logic [DW-1:0]     r_issue_info;

   logic [DP-1:0]     w_ready;
   logic [DP-1:0]     w_grant;
   logic              w_grant_vld;
   logic              w_take;
   logic [DP-1:0]     w_free;
   logic              w_push;
   logic [DP-1:0]     w_alloc;
   logic [DW-1:0]     w_sel_info;

   assign buffer_malloc = r_valid;
   assign buffer_full   = &r_valid;
   assign issue_valid   = (r_state == StFull);
   assign issue_info    = r_issue_info;

   // Lowest clear bit of the registered valids; a slot freed this cycle is not reused yet.
   assign w_alloc = ~r_valid & (r_valid + DP'(1));
   assign w_push  = buffer_push & ~buffer_full & ~flush;
   assign w_take  = w_grant_vld & (~issue_valid | issue_ready) & ~flush;
   assign w_free  = w_take ? w_grant : '0;

   // Wake entries whose needed sources are marked written this cycle.
   always_comb begin
      w_ready = '0;
      for (int i = 0; i < DP; i++) begin
         w_ready[i] = r_valid[i] & src_ok(r_need1[i], r_src1[i], wb_written)
                                 & src_ok(r_need2[i], r_src2[i], wb_written);
      end
   end

   issue_age_select #(
      .DP (DP)
   ) u_age_select (
      .i_ready     (w_ready),
      .i_old       (r_old),
      .o_grant     (w_grant),
      .o_grant_vld (w_grant_vld)
   );

   // One-hot mux of the granted entry's payload.
   always_comb begin
      w_sel_info = '0;
      for (int i = 0; i < DP; i++) begin
         if (w_grant[i]) w_sel_info = w_sel_info | r_payload[i];
      end
   end

   // Entry valid bits: flush clears, select frees, push allocates.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_valid <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         r_valid <= (r_valid & ~w_free) | (w_push ? w_alloc : '0);
      end
   end

   // Entry payload and source fields; data only, qualified by r_valid.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < DP; i++) begin
         if (w_push && w_alloc[i]) begin
            r_payload[i] <= dispat_info;
            r_src1[i]    <= src1_name;
            r_src2[i]    <= src2_name;
            r_need1[i]   <= src1_need;
            r_need2[i]   <= src2_need;
         end
      end
   end

   // Age matrix: new entry is younger than every surviving valid entry.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DP; i++) r_old[i] <= '0;
      end else if (w_push) begin
         for (int i = 0; i < DP; i++) begin
            if (w_alloc[i]) begin
               r_old[i] <= '0;
            end else begin
               r_old[i] <= (r_old[i] & ~w_alloc) |
                           ((r_valid[i] & ~w_free[i]) ? w_alloc : '0);
            end
         end
      end
   end

   // Output stage next state: load on select, drain when accepted with nothing new.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StEmpty: if (w_take) w_state_nxt = StFull;
         StFull:  if (issue_ready && !w_take) w_state_nxt = StEmpty;
         default: w_state_nxt = StEmpty;
      endcase
      if (flush) w_state_nxt = StEmpty;
   end

   // Output stage registers; payload held stable while stalled.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state      <= StEmpty;
         r_issue_info <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) r_issue_info <= w_sel_info;
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with an expected-issue scoreboard.
module tb_issue_scheduler;
   import issue_scheduler_pkg::*;

   localparam int unsigned DP = ISQ_DP;
   localparam int unsigned DW = ISQ_DW;

   logic              CLK = 1'b0;
   logic              RSTn = 1'b1;
   logic              flush = 1'b0;
   logic              buffer_push = 1'b0;
   logic              buffer_full;
   logic [DP-1:0]     buffer_malloc;
   logic [DW-1:0]     dispat_info = '0;
   logic [NAME_W-1:0] src1_name = '0;
   logic [NAME_W-1:0] src2_name = '0;
   logic              src1_need = 1'b0;
   logic              src2_need = 1'b0;
   logic [WB_W-1:0]   wb_written = '0;
   logic              issue_valid;
   logic              issue_ready = 1'b0;
   logic [DW-1:0]     issue_info;

   logic [DW-1:0] sb [$];
   int total = 0;
   int bad = 0;

   issue_scheduler #(
      .DP (DP),
      .DW (DW)
   ) dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .flush         (flush),
      .buffer_push   (buffer_push),
      .buffer_full   (buffer_full),
      .buffer_malloc (buffer_malloc),
      .dispat_info   (dispat_info),
      .src1_name     (src1_name),
      .src2_name     (src2_name),
      .src1_need     (src1_need),
      .src2_need     (src2_need),
      .wb_written    (wb_written),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_info    (issue_info)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] pl(input int t);
      return {32'(t), 96'h5a5a_0000_1234_0000_c3c3_0000, 32'(t)};
   endfunction

   function automatic logic [NAME_W-1:0] nm(input int a, input int b);
      return NAME_W'((a << ISQ_RB) | b);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_op(input int t, input logic n1, input int a1, input logic n2, input int a2);
      buffer_push = 1'b1;
      dispat_info = pl(t);
      src1_need   = n1;
      src1_name   = nm(a1, 0);
      src2_need   = n2;
      src2_name   = nm(a2, 0);
      tick();
      buffer_push = 1'b0;
      src1_need   = 1'b0;
      src2_need   = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      tick();
      chk(tag, DW'(sb.size()), '0);
   endtask

   // Monitor: protocol check on push, scoreboard pop on each accepted issue.
   always @(negedge CLK) begin
      if (RSTn) begin
         if (buffer_push) chk("push_while_full", DW'(buffer_full), '0);
         if (issue_valid && issue_ready && !flush) begin
            chk("issue_expected", DW'(sb.size() != 0), DW'(1));
            if (sb.size() != 0) chk("issue_order", issue_info, sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle
      #2 RSTn = 1'b0;
      #3;
      chk("rst_full", DW'(buffer_full), '0);
      chk("rst_malloc", DW'(buffer_malloc), '0);
      chk("rst_valid", DW'(issue_valid), '0);
      chk("rst_info", issue_info, '0);
      @(negedge CLK) RSTn = 1'b1;
      tick();

      // Single op latency
      issue_ready = 1'b1;
      sb.push_back(pl('hA0));
      push_op('hA0, 0, 0, 0, 0);
      chk("lat_malloc_e", DW'(buffer_malloc), DW'(1));
      chk("lat_valid_e", DW'(issue_valid), '0);
      tick();
      chk("lat_valid_e1", DW'(issue_valid), DW'(1));
      chk("lat_info_e1", issue_info, pl('hA0));
      chk("lat_malloc_e1", DW'(buffer_malloc), '0);
      tick();
      chk("lat_valid_e2", DW'(issue_valid), '0);

      // Wakeup ordering
      wb_written = '0;
      buffer_push = 1'b1; dispat_info = pl('hB1); src1_need = 1'b1; src1_name = nm(3, 1);
      tick();
      push_op('hB2, 1, 4, 0, 0);
      sb.push_back(pl('hB3));
      push_op('hB3, 0, 0, 0, 0);
      wait_drain("wake_c");
      chk("wake_occ2", DW'($countones(buffer_malloc)), DW'(2));
      sb.push_back(pl('hB2));
      wb_written[4*4+0] = 1'b1;
      wait_drain("wake_b");
      chk("wake_occ1", DW'($countones(buffer_malloc)), DW'(1));
      sb.push_back(pl('hB1));
      wb_written[3*4+1] = 1'b1;
      wait_drain("wake_a");
      chk("wake_occ0", DW'(buffer_malloc), '0);

      // Age priority with simultaneous wakeup
      wb_written = '0;
      push_op('hC1, 1, 5, 0, 0);
      push_op('hC2, 0, 0, 1, 6);
      push_op('hC3, 1, 7, 1, 7);
      sb.push_back(pl('hC1)); sb.push_back(pl('hC2)); sb.push_back(pl('hC3));
      wb_written = '1;
      tick();
      chk("age_first", issue_info, pl('hC1));
      tick();
      chk("age_second", issue_info, pl('hC2));
      tick();
      chk("age_third", issue_info, pl('hC3));
      tick();
      chk("age_done", DW'(issue_valid), '0);

      // Backpressure
      issue_ready = 1'b0;
      wb_written  = '0;
      push_op('hD1, 0, 0, 0, 0);
      push_op('hD2, 0, 0, 0, 0);
      push_op('hD3, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", DW'(issue_valid), DW'(1));
         chk("bp_info", issue_info, pl('hD1));
         chk("bp_occupancy", DW'($countones(buffer_malloc)), DW'(2));
         tick();
      end
      sb.push_back(pl('hD1)); sb.push_back(pl('hD2)); sb.push_back(pl('hD3));
      issue_ready = 1'b1;
      tick();
      chk("bp_drain1", issue_info, pl('hD2));
      tick();
      chk("bp_drain2", issue_info, pl('hD3));
      tick();
      chk("bp_drain_done", DW'(issue_valid), '0);

      // Full boundary
      for (int i = 0; i < 8; i++) push_op('h50 + i, 1, 8 + i, 0, 0);
      chk("full_flag", DW'(buffer_full), DW'(1));
      chk("full_malloc", DW'(buffer_malloc), DW'(8'hFF));
      sb.push_back(pl('h53));
      wb_written[11*4] = 1'b1;
      tick();
      chk("full_freed_flag", DW'(buffer_full), '0);
      chk("full_freed_malloc", DW'(buffer_malloc), DW'(8'hF7));
      push_op('h58, 1, 20, 0, 0);
      chk("full_reuse_malloc", DW'(buffer_malloc), DW'(8'hFF));
      for (int i = 0; i < 8; i++) if (i != 3) sb.push_back(pl('h50 + i));
      sb.push_back(pl('h58));
      wb_written = '1;
      wait_drain("full_drain");
      chk("full_empty", DW'(buffer_malloc), '0);

      // Flush with a staged op and queued ops
      issue_ready = 1'b0;
      wb_written  = '0;
      push_op('h60, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) push_op('h61 + i, 1, 21 + i, 0, 0);
      chk("fl_pre_occ", DW'($countones(buffer_malloc)), DW'(5));
      chk("fl_pre_valid", DW'(issue_valid), DW'(1));
      chk("fl_pre_info", issue_info, pl('h60));
      flush = 1'b1;
      push_op('h66, 0, 0, 0, 0);
      flush = 1'b0;
      chk("fl_malloc", DW'(buffer_malloc), '0);
      chk("fl_valid", DW'(issue_valid), '0);
      issue_ready = 1'b1;
      wb_written  = '1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("fl_no_issue", DW'(issue_valid), '0);
      end

      // Reset asserted mid-operation
      issue_ready = 1'b0;
      wb_written  = '0;
      push_op('h70, 1, 30, 0, 0);
      push_op('h71, 0, 0, 0, 0);
      tick();
      chk("mrst_pre_valid", DW'(issue_valid), DW'(1));
      #2 RSTn = 1'b0;
      #1;
      chk("mrst_malloc", DW'(buffer_malloc), '0);
      chk("mrst_valid", DW'(issue_valid), '0);
      chk("mrst_info", issue_info, '0);
      @(negedge CLK) RSTn = 1'b1;
      tick();
      chk("mrst_sb_empty", DW'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
